// File: rtl/row_ctrl_pkg.sv
// Shared definitions for the row/column/kernel controllers: sequencer state
// encoding and the geometry validity check.
package row_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CFG    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    // Arguments are zero-extended by the caller; counts up to 32 bits are supported.
    function automatic logic geom_ok(input logic [31:0] cols, input logic [31:0] rows);
        return (cols != 32'd0) && (rows != 32'd0);
    endfunction

endpackage

// File: rtl/pos_counter.sv
// Column/row position counter pair: column wraps at cols-1 and carries into the
// row, which wraps at rows-1.
module pos_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] cols,
    input  logic [W-1:0] rows,
    output logic [W-1:0] col,
    output logic [W-1:0] row,
    output logic         last_col,
    output logic         last_row
);

    logic [W-1:0] col_q, col_d;
    logic [W-1:0] row_q, row_d;

    assign col      = col_q;
    assign row      = row_q;
    assign last_col = (col_q == cols - W'(1));
    assign last_row = (row_q == rows - W'(1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (inc) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + W'(1);
            end else begin
                col_d = col_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/row_ctrl.sv
// Frame sequencer for the row delay line: programs a one-row delay into
// delay_mem, then forwards the pixel stream tagged with position and frame markers.
module row_ctrl
    import row_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_AWIDTH-1:0] cfg_cols,
    input  logic [MEM_AWIDTH-1:0] cfg_rows,
    input  logic                  cfg_val,
    output logic                  cfg_rdy,
    output logic                  cfg_err,
    input  logic [IMG_WIDTH-1:0]  up_data,
    input  logic                  up_val,
    output logic                  up_rdy,
    output logic [MEM_AWIDTH-1:0] mem_cfg_delay,
    output logic                  mem_cfg_set,
    output logic [IMG_WIDTH-1:0]  mem_data,
    output logic                  mem_val,
    output logic [MEM_AWIDTH-1:0] pos_col,
    output logic [MEM_AWIDTH-1:0] pos_row,
    output logic                  pos_sof,
    output logic                  pos_eol,
    output logic                  pos_eof,
    output logic                  frame_done
);

    state_e state_q, state_d;
    logic   cfg_take, cfg_bad, accept;

    logic [MEM_AWIDTH-1:0] cols_q, rows_q;
    logic [MEM_AWIDTH-1:0] col, row;
    logic                  last_col, last_row;

    logic                  cfg_err_q;
    logic [IMG_WIDTH-1:0]  mem_data_q;
    logic                  mem_val_q;
    logic [MEM_AWIDTH-1:0] pos_col_q, pos_row_q;
    logic                  sof_q, eol_q, eof_q, done_q;

    // Handshake readies decode the state register only.
    assign cfg_rdy       = (state_q == ST_IDLE);
    assign up_rdy        = (state_q == ST_RUN);
    assign accept        = up_val && (state_q == ST_RUN);
    assign mem_cfg_set   = (state_q == ST_CFG);
    assign mem_cfg_delay = cols_q;

    always_comb begin
        state_d  = state_q;
        cfg_take = 1'b0;
        cfg_bad  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_val) begin
                    if (geom_ok(32'(cfg_cols), 32'(cfg_rows))) begin
                        cfg_take = 1'b1;
                        state_d  = ST_CFG;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            ST_CFG:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_RUN;
            ST_RUN: begin
                if (accept && last_col && last_row) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    pos_counter #(.W(MEM_AWIDTH)) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (cfg_take),
        .inc      (accept),
        .cols     (cols_q),
        .rows     (rows_q),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_row (last_row)
    );

    // Markers and valid clear on stall cycles; data and position simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cols_q     <= '0;
            rows_q     <= '0;
            cfg_err_q  <= 1'b0;
            mem_data_q <= '0;
            mem_val_q  <= 1'b0;
            pos_col_q  <= '0;
            pos_row_q  <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cfg_err_q <= cfg_bad;
            if (cfg_take) begin
                cols_q <= cfg_cols;
                rows_q <= cfg_rows;
            end
            mem_val_q <= accept;
            sof_q     <= accept && (col == '0) && (row == '0);
            eol_q     <= accept && last_col;
            eof_q     <= accept && last_col && last_row;
            done_q    <= accept && last_col && last_row;
            if (accept) begin
                mem_data_q <= up_data;
                pos_col_q  <= col;
                pos_row_q  <= row;
            end
        end
    end

    assign cfg_err    = cfg_err_q;
    assign mem_data   = mem_data_q;
    assign mem_val    = mem_val_q;
    assign pos_col    = pos_col_q;
    assign pos_row    = pos_row_q;
    assign pos_sof    = sof_q;
    assign pos_eol    = eol_q;
    assign pos_eof    = eof_q;
    assign frame_done = done_q;

endmodule
